// File: rtl/adc_frame_builder.sv
// ADC01 serial-stream deserialiser: assembles tagged conversion words and
// queues them in a first-word-fall-through FIFO for a FIFO_READ/FIFO_EMPTY consumer.
module adc_frame_builder #(
  parameter int unsigned DATA_BITS       = 12,
  parameter logic [3:0]  IDENTIFIER      = 4'b1011,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic        SDI,
  input  logic        SEN,
  input  logic [2:0]  CH_SEL,
  input  logic        FIFO_READ,
  output logic        FIFO_EMPTY,
  output logic [31:0] FIFO_DATA,
  output logic        FIFO_FULL,
  output logic [7:0]  LOST_COUNT,
  output logic        FRAME_ACTIVE,
  output logic [1:0]  STATE_DBG
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PUSH = 2'd2} state_e;

  localparam int unsigned PW    = FIFO_DEPTH_LOG2;
  localparam int unsigned CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [4:0]    CNT_EXACT = 5'(DATA_BITS);
  localparam logic [4:0]    CNT_SAT   = 5'(DATA_BITS + 1);
  localparam logic [15:0]   DATA_MASK = 16'((32'd1 << DATA_BITS) - 32'd1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] OCC_ONE   = CW'(1);
  localparam logic [CW-1:0] OCC_FULL  = CW'(DEPTH);

  state_e         state_q, state_d;
  logic [15:0]    shreg_q, shreg_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [2:0]     ch_q, ch_d;
  logic [7:0]     frame_q, frame_d;
  logic [7:0]     lost_q, lost_d;
  logic           active_q, active_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  occ_q, occ_d;
  logic           empty_q, empty_d, full_q, full_d;
  logic [31:0]    mem_q [DEPTH];
  logic           push, pop;
  logic [31:0]    push_word;

  // Frame FSM: the bit counter saturates so an overlong frame still flags an error.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    frame_d = frame_q;
    lost_d  = lost_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ENABLE && SEN) begin
          shreg_d = {15'd0, SDI};
          cnt_d   = 5'd1;
          ch_d    = CH_SEL;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (SEN) begin
          shreg_d = {shreg_q[14:0], SDI};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 5'd1;
        end else begin
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        frame_d = frame_q + 8'd1;
        if (!full_q) push = 1'b1;
        else if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    active_d = (state_d == S_SHIFT);
  end

  assign push_word = {IDENTIFIER, ch_q, (cnt_q != CNT_EXACT), frame_q, shreg_q & DATA_MASK};

  // A push while full is refused even when a pop lands in the same cycle.
  always_comb begin
    pop      = FIFO_READ && !empty_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    occ_d    = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
    empty_d = (occ_d == '0);
    full_d  = (occ_d == OCC_FULL);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      ch_q     <= '0;
      frame_q  <= '0;
      lost_q   <= '0;
      active_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      frame_q  <= frame_d;
      lost_q   <= lost_d;
      active_q <= active_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  assign FIFO_DATA    = empty_q ? 32'd0 : mem_q[rd_ptr_q];
  assign FIFO_EMPTY   = empty_q;
  assign FIFO_FULL    = full_q;
  assign LOST_COUNT   = lost_q;
  assign FRAME_ACTIVE = active_q;
  assign STATE_DBG    = state_q;

endmodule
